// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline definitions: datapath widths and the operand
// forwarding-source encoding used by the ID/EX stage.
package riscv_pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_ADR_W = 5;
  localparam int unsigned CTRL_W    = 16;
  localparam int unsigned CNT_W     = 16;

  typedef logic [REG_ADR_W-1:0] reg_adr_t;

  typedef enum logic [2:0] {
    FWD_ZERO,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_RF
  } fwd_sel_e;

  // Saturating increment; the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc16(logic [CNT_W-1:0] val);
    return (val == {CNT_W{1'b1}}) ? val : val + CNT_W'(1);
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bus between decode/forwarding sources and the ID/EX operand stage.
// The stage uses the slave modport; the driving pipeline uses master.
interface id_ex_operand_stage_if
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XW = riscv_pipe_pkg::XLEN,
  parameter int unsigned CW = riscv_pipe_pkg::CTRL_W,
  parameter int unsigned NW = riscv_pipe_pkg::CNT_W
);

  // Decode slot
  logic           ID_Valid;
  reg_adr_t       R1Adr;
  reg_adr_t       R2Adr;
  logic [XW-1:0]  R1;
  logic [XW-1:0]  R2;
  logic           ID_R1Used;
  logic           ID_R2Used;
  reg_adr_t       ID_RdAdr;
  logic           ID_RegWrite;
  logic           ID_IsLoad;
  logic [XW-1:0]  ID_Imm;
  logic [XW-1:0]  ID_PC;
  logic [CW-1:0]  ID_Ctrl;

  // Bypass sources
  logic [XW-1:0]  EX_Result;
  logic           MEM_WE;
  reg_adr_t       MEM_RdAdr;
  logic [XW-1:0]  MEM_Data;
  logic           WB_WE;
  reg_adr_t       WB_WAdr;
  logic [XW-1:0]  WB_Din;
  logic           Flush;

  // Stage outputs
  logic           Stall;
  logic           EX_Valid;
  logic [XW-1:0]  EX_A;
  logic [XW-1:0]  EX_B;
  logic [XW-1:0]  EX_Imm;
  logic [XW-1:0]  EX_PC;
  reg_adr_t       EX_RdAdr;
  logic           EX_RegWrite;
  logic           EX_IsLoad;
  logic [CW-1:0]  EX_Ctrl;
  logic [NW-1:0]  StallCnt;
  logic [NW-1:0]  FlushCnt;

  modport master (
    output ID_Valid, R1Adr, R2Adr, R1, R2, ID_R1Used, ID_R2Used, ID_RdAdr,
           ID_RegWrite, ID_IsLoad, ID_Imm, ID_PC, ID_Ctrl,
           EX_Result, MEM_WE, MEM_RdAdr, MEM_Data, WB_WE, WB_WAdr, WB_Din, Flush,
    input  Stall, EX_Valid, EX_A, EX_B, EX_Imm, EX_PC, EX_RdAdr, EX_RegWrite,
           EX_IsLoad, EX_Ctrl, StallCnt, FlushCnt
  );

  modport slave (
    input  ID_Valid, R1Adr, R2Adr, R1, R2, ID_R1Used, ID_R2Used, ID_RdAdr,
           ID_RegWrite, ID_IsLoad, ID_Imm, ID_PC, ID_Ctrl,
           EX_Result, MEM_WE, MEM_RdAdr, MEM_Data, WB_WE, WB_WAdr, WB_Din, Flush,
    output Stall, EX_Valid, EX_A, EX_B, EX_Imm, EX_PC, EX_RdAdr, EX_RegWrite,
           EX_IsLoad, EX_Ctrl, StallCnt, FlushCnt
  );

endinterface

// File: rtl/operand_fwd_mux.sv
// Per-operand bypass selection: x0, then EX, MEM, WB, else register file.
// Nearest producer wins so the newest value of a register is always taken.
module operand_fwd_mux
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned DataW = riscv_pipe_pkg::XLEN
) (
  input  reg_adr_t         adr_i,
  input  logic             ex_we_i,
  input  reg_adr_t         ex_adr_i,
  input  logic [DataW-1:0] ex_data_i,
  input  logic             mem_we_i,
  input  reg_adr_t         mem_adr_i,
  input  logic [DataW-1:0] mem_data_i,
  input  logic             wb_we_i,
  input  reg_adr_t         wb_adr_i,
  input  logic [DataW-1:0] wb_data_i,
  input  logic [DataW-1:0] rf_data_i,
  output logic [DataW-1:0] operand_o
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_RF;
    if (adr_i == '0) begin
      sel = FWD_ZERO;
    end else if (ex_we_i && (ex_adr_i == adr_i)) begin
      sel = FWD_EX;
    end else if (mem_we_i && (mem_adr_i == adr_i)) begin
      sel = FWD_MEM;
    end else if (wb_we_i && (wb_adr_i == adr_i)) begin
      // The register file writes on the same edge, so its read port is still stale.
      sel = FWD_WB;
    end
  end

  always_comb begin
    operand_o = rf_data_i;
    unique case (sel)
      FWD_ZERO: operand_o = '0;
      FWD_EX:   operand_o = ex_data_i;
      FWD_MEM:  operand_o = mem_data_i;
      FWD_WB:   operand_o = wb_data_i;
      FWD_RF:   operand_o = rf_data_i;
      default:  operand_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register of the RV32I core with operand forwarding,
// load-use stall/bubble insertion, branch flush and saturating event counters.
module id_ex_operand_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = riscv_pipe_pkg::XLEN,
  parameter int unsigned CTRL_W = riscv_pipe_pkg::CTRL_W,
  parameter int unsigned CNT_W  = riscv_pipe_pkg::CNT_W
) (
  input logic                  CLK,
  input logic                  RST_N,
  id_ex_operand_stage_if.slave bus
);

  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_a_q;
  logic [XLEN-1:0]   ex_b_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [XLEN-1:0]   ex_pc_q;
  reg_adr_t          ex_rd_q;
  logic              ex_regwrite_q;
  logic              ex_isload_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              ex_fwd_en;
  logic              r1_hit;
  logic              r2_hit;
  logic              load_use;
  logic              stall;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;

  // A load in EX has no data yet; it is covered by the stall, then by MEM forwarding.
  assign ex_fwd_en = ex_valid_q & ex_regwrite_q & ~ex_isload_q;

  operand_fwd_mux #(
    .DataW (XLEN)
  ) u_fwd_a (
    .adr_i      (bus.R1Adr),
    .ex_we_i    (ex_fwd_en),
    .ex_adr_i   (ex_rd_q),
    .ex_data_i  (bus.EX_Result),
    .mem_we_i   (bus.MEM_WE),
    .mem_adr_i  (bus.MEM_RdAdr),
    .mem_data_i (bus.MEM_Data),
    .wb_we_i    (bus.WB_WE),
    .wb_adr_i   (bus.WB_WAdr),
    .wb_data_i  (bus.WB_Din),
    .rf_data_i  (bus.R1),
    .operand_o  (op_a)
  );

  operand_fwd_mux #(
    .DataW (XLEN)
  ) u_fwd_b (
    .adr_i      (bus.R2Adr),
    .ex_we_i    (ex_fwd_en),
    .ex_adr_i   (ex_rd_q),
    .ex_data_i  (bus.EX_Result),
    .mem_we_i   (bus.MEM_WE),
    .mem_adr_i  (bus.MEM_RdAdr),
    .mem_data_i (bus.MEM_Data),
    .wb_we_i    (bus.WB_WE),
    .wb_adr_i   (bus.WB_WAdr),
    .wb_data_i  (bus.WB_Din),
    .rf_data_i  (bus.R2),
    .operand_o  (op_b)
  );

  always_comb begin
    r1_hit   = bus.ID_R1Used & (ex_rd_q == bus.R1Adr);
    r2_hit   = bus.ID_R2Used & (ex_rd_q == bus.R2Adr);
    load_use = bus.ID_Valid & ex_valid_q & ex_isload_q & (ex_rd_q != '0) & (r1_hit | r2_hit);
    stall    = load_use & ~bus.Flush;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_valid_q    <= 1'b0;
      ex_a_q        <= '0;
      ex_b_q        <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
      ex_rd_q       <= '0;
      ex_regwrite_q <= 1'b0;
      ex_isload_q   <= 1'b0;
      ex_ctrl_q     <= '0;
    end else if (bus.Flush || stall) begin
      // Bubble: only the qualifying flags are cleared, data fields hold.
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_isload_q   <= 1'b0;
    end else begin
      ex_valid_q    <= bus.ID_Valid;
      ex_a_q        <= op_a;
      ex_b_q        <= op_b;
      ex_imm_q      <= bus.ID_Imm;
      ex_pc_q       <= bus.ID_PC;
      ex_rd_q       <= bus.ID_RdAdr;
      ex_regwrite_q <= bus.ID_RegWrite & bus.ID_Valid;
      ex_isload_q   <= bus.ID_IsLoad & bus.ID_Valid;
      ex_ctrl_q     <= bus.ID_Ctrl;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.Flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.Stall       = stall;
  assign bus.EX_Valid    = ex_valid_q;
  assign bus.EX_A        = ex_a_q;
  assign bus.EX_B        = ex_b_q;
  assign bus.EX_Imm      = ex_imm_q;
  assign bus.EX_PC       = ex_pc_q;
  assign bus.EX_RdAdr    = ex_rd_q;
  assign bus.EX_RegWrite = ex_regwrite_q;
  assign bus.EX_IsLoad   = ex_isload_q;
  assign bus.EX_Ctrl     = ex_ctrl_q;
  assign bus.StallCnt    = stall_cnt_q;
  assign bus.FlushCnt    = flush_cnt_q;

endmodule
